// File: rtl/seq_acc_sched.sv
// seq_acc_sched: job scheduler feeding the sequential MAC accelerator.
// Define SEQ_ACC_SCHED_PERF_EN to add busy/stall cycle counters.
module seq_acc_sched #(
  parameter int IN_BITS    = 5,
  parameter int IN_ELEMS   = 128,
  parameter int OUT_ELEMS  = 32,
  parameter int ACC_BITS   = 16,
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start_i,
  input  logic [ADDR_BITS-1:0]          num_vectors_i,
  input  logic [ADDR_BITS-1:0]          in_base_i,
  input  logic [ADDR_BITS-1:0]          out_base_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          act_rd_en_o,
  output logic [ADDR_BITS-1:0]          act_rd_addr_o,
  input  logic [IN_ELEMS*IN_BITS-1:0]   act_rd_data_i,
  output logic                          acc_valid_o,
  output logic [IN_ELEMS*IN_BITS-1:0]   acc_data_o,
  input  logic                          acc_ready_i,
  input  logic                          acc_res_valid_i,
  input  logic [OUT_ELEMS*ACC_BITS-1:0] acc_res_data_i,
  output logic                          out_wr_en_o,
  output logic [ADDR_BITS-1:0]          out_wr_addr_o,
  output logic [OUT_ELEMS*ACC_BITS-1:0] out_wr_data_o,
`ifdef SEQ_ACC_SCHED_PERF_EN
  output logic [31:0]                   busy_cycles_o,
  output logic [31:0]                   stall_cycles_o,
`endif
  input  logic                          out_wr_ready_i
);

  localparam int AW = ADDR_BITS;
  localparam int IW = IN_ELEMS * IN_BITS;
  localparam int OW = OUT_ELEMS * ACC_BITS;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, ISSUE, DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] num_q;
  logic [AW-1:0] in_base_q;
  logic [AW-1:0] out_base_q;
  logic [AW-1:0] issued_q;
  logic [AW-1:0] retired_q;
  logic [AW-1:0] written_q;
  logic [IW-1:0] hold_q;
  logic          busy_q;
  logic          done_q;

  logic [OW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] used_q;

  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic [AW-1:0] issued_inc;
  logic [AW-1:0] written_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // used_q = in-flight + FIFO occupancy; a free credit is a free slot
  assign accept      = (state == IDLE) && start_i && (num_vectors_i != '0);
  assign acc_valid_o = (state == ISSUE) && (used_q != CW'(FIFO_DEPTH));
  assign issue       = acc_valid_o && acc_ready_i;
  assign push        = acc_res_valid_i;
  assign full        = (cnt_q == CW'(FIFO_DEPTH));
  assign out_wr_en_o = (cnt_q != '0);
  assign pop         = out_wr_en_o && out_wr_ready_i;
  assign issued_inc  = issued_q + 1'b1;
  assign written_nxt = written_q + AW'(pop);

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign act_rd_en_o   = (state == FETCH);
  assign act_rd_addr_o = in_base_q + issued_q;
  assign acc_data_o    = hold_q;
  assign out_wr_addr_o = out_base_q + written_q;
  assign out_wr_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      used_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= acc_res_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      used_q <= used_q + CW'(issue) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      num_q      <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      written_q  <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      written_q <= written_nxt;
      if (push) retired_q <= retired_q + 1'b1;
      unique case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            num_q      <= num_vectors_i;
            in_base_q  <= in_base_i;
            out_base_q <= out_base_i;
            issued_q   <= '0;
            retired_q  <= '0;
            written_q  <= '0;
            busy_q     <= 1'b1;
            state      <= FETCH;
          end else if (start_i) begin
            done_q <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          hold_q <= act_rd_data_i;
          state  <= ISSUE;
        end
        ISSUE: begin
          if (issue) begin
            issued_q <= issued_inc;
            state    <= (issued_inc < num_q) ? FETCH : DRAIN;
          end
        end
        DRAIN: begin
          if (written_nxt == num_q) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_ACC_SCHED_PERF_EN
  logic stall;
  assign stall = (state == ISSUE) &&
                 ((acc_valid_o && !acc_ready_i) ||
                  (used_q == CW'(FIFO_DEPTH)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_cycles_o  <= '0;
      stall_cycles_o <= '0;
    end else if (accept) begin
      busy_cycles_o  <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (busy_q && (busy_cycles_o != '1))
        busy_cycles_o <= busy_cycles_o + 1'b1;
      if (stall && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end
`endif

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!nrst) !(push && full && !pop)
  ) else $error("result pushed into full skid FIFO");

  a_retire_order: assert property (
    @(posedge clk) disable iff (!nrst) retired_q <= issued_q
  ) else $error("more results retired than issued");

endmodule
